cheshire_idma_desc_fetch: RTL

Linked-list descriptor frontend for the Cheshire iDMA. It walks a chain of in-memory descriptors through a single-outstanding request/grant memory port. Each descriptor becomes one 1D job (src, dst, len) on a valid/ready stream feeding the DMA job FIFO and backend. It counts retired jobs and raises a sticky completion interrupt when the chain is drained.

---
 rtl/cheshire_idma_desc_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cheshire_idma_desc_fetch.sv
// Linked-list descriptor frontend for the Cheshire iDMA: fetches 4-word
// descriptors over a single-outstanding memory port and emits one 1D job each.
module cheshire_idma_desc_fetch #(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned LenWidth    = 32,
   parameter int unsigned MaxInFlight = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] head_addr_i,
   input  logic                 irq_clr_i,
   output logic                 busy_o,
   output logic                 irq_o,
   output logic                 error_o,
   output logic [31:0]          jobs_done_o,
   output logic                 mem_req_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [63:0]          mem_rdata_i,
   input  logic                 mem_err_i,
   output logic                 job_valid_o,
   input  logic                 job_ready_i,
   output logic [AddrWidth-1:0] job_src_o,
   output logic [AddrWidth-1:0] job_dst_o,
   output logic [LenWidth-1:0]  job_len_o,
   input  logic                 job_done_i
);

   localparam int unsigned CntWidth = $clog2(MaxInFlight + 1);
   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxInFlight);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StEmit, StDrain} state_e;

   state_e               state, state_next;
   logic [AddrWidth-1:0] cur, cur_next;
   logic [1:0]           k, k_next;
   logic [AddrWidth-1:0] next_ptr, src, dst;
   logic [LenWidth-1:0]  len;
   logic [CntWidth-1:0]  inflight, inflight_next;
   logic [31:0]          jobs_done;
   logic                 irq, error;
   logic                 irq_set, err_set, clr_jobs;
   logic                 job_hs, done_cnt, desc_done;

   // All outputs decode registered state only, so no input reaches them combinationally.
   assign busy_o      = (state != StIdle);
   assign mem_req_o   = (state == StReq);
   assign mem_addr_o  = cur + AddrWidth'({k, 3'b000});
   assign job_valid_o = (state == StEmit) && (len != '0) && (inflight < MaxCnt);
   assign job_src_o   = src;
   assign job_dst_o   = dst;
   assign job_len_o   = len;
   assign irq_o       = irq;
   assign error_o     = error;
   assign jobs_done_o = jobs_done;

   assign job_hs   = job_valid_o & job_ready_i;
   // Retire pulses with nothing in flight are spurious and dropped.
   assign done_cnt = job_done_i & (inflight != '0);

   // In-flight job counter update.
   always_comb begin
      inflight_next = inflight;
      unique case ({job_hs, done_cnt})
         2'b10:   inflight_next = inflight + CntWidth'(1);
         2'b01:   inflight_next = inflight - CntWidth'(1);
         default: inflight_next = inflight;
      endcase
   end

   // Chain-walk FSM next state and flag set requests.
   always_comb begin
      state_next = state;
      cur_next   = cur;
      k_next     = k;
      irq_set    = 1'b0;
      err_set    = 1'b0;
      clr_jobs   = 1'b0;
      desc_done  = 1'b0;
      unique case (state)
         StIdle: begin
            if (start_i) begin
               if (head_addr_i == '0) begin
                  irq_set = 1'b1;
               end else if (head_addr_i[2:0] != 3'b000) begin
                  err_set = 1'b1;
                  irq_set = 1'b1;
               end else begin
                  cur_next   = head_addr_i;
                  k_next     = 2'd0;
                  clr_jobs   = 1'b1;
                  state_next = StReq;
               end
            end
         end
         StReq: begin
            if (mem_gnt_i) state_next = StWait;
         end
         StWait: begin
            if (mem_rvalid_i) begin
               if (mem_err_i) begin
                  err_set    = 1'b1;
                  state_next = StDrain;
               end else if (k != 2'd3) begin
                  k_next     = k + 2'd1;
                  state_next = StReq;
               end else begin
                  state_next = StEmit;
               end
            end
         end
         StEmit: begin
            // Zero-length descriptors are skipped without producing a job.
            desc_done = (len == '0) | job_hs;
            if (desc_done) begin
               if (next_ptr == '0) begin
                  state_next = StDrain;
               end else if (next_ptr[2:0] != 3'b000) begin
                  err_set    = 1'b1;
                  state_next = StDrain;
               end else begin
                  cur_next   = next_ptr;
                  k_next     = 2'd0;
                  state_next = StReq;
               end
            end
         end
         StDrain: begin
            // Look at the next count so the final retire raises irq one cycle later.
            if (inflight_next == '0) begin
               irq_set    = 1'b1;
               state_next = StIdle;
            end
         end
         default: state_next = StIdle;
      endcase
   end

   // Control state, counters and sticky flags; a set beats a same-cycle clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= StIdle;
         cur       <= '0;
         k         <= 2'd0;
         inflight  <= '0;
         jobs_done <= '0;
         irq       <= 1'b0;
         error     <= 1'b0;
      end else begin
         state    <= state_next;
         cur      <= cur_next;
         k        <= k_next;
         inflight <= inflight_next;
         irq      <= irq_set | (irq & ~irq_clr_i);
         error    <= err_set | (error & ~irq_clr_i);
         if (clr_jobs) begin
            jobs_done <= '0;
         end else if (done_cnt) begin
            jobs_done <= jobs_done + 32'd1;
         end
      end
   end

   // Descriptor word capture, indexed by the word currently being fetched.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         next_ptr <= '0;
         src      <= '0;
         dst      <= '0;
         len      <= '0;
      end else if (state == StWait && mem_rvalid_i) begin
         unique case (k)
            2'd0: next_ptr <= mem_rdata_i[AddrWidth-1:0];
            2'd1: src      <= mem_rdata_i[AddrWidth-1:0];
            2'd2: dst      <= mem_rdata_i[AddrWidth-1:0];
            2'd3: len      <= mem_rdata_i[LenWidth-1:0];
            default: ;
         endcase
      end
   end

endmodule
